ppu_stype_rx: RTL and testbench

- PPU-side receiver for the CPU's S-type write channel (PPU_en, S_type_index, S_type_value).
- Buffers CPU writes in a small FIFO and replays them, in order, onto the PPU's internal memory write port, only when the PPU allows it (vertical blank).
- Decodes one reserved index as a local control register.
- Signals full/overflow status back toward the CPU so it can stall.

---
 rtl/ppu_stype_rx_if.sv | 49 ++++
 rtl/ppu_stype_rx.sv | 192 +++++++++++++++++++
 tb/tb_ppu_stype_rx.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ppu_stype_rx_if.sv
// ppu_stype_rx_if
//   Bundles the CPU S-type write channel, the PPU memory write port and the
//   status/control outputs of ppu_stype_rx.
//
//   Handshake semantics (the only handshake on this bus):
//     * CPU side: PPU_en is a one-cycle write strobe with no ready. Each cycle
//       it is high, one {S_type_index, S_type_value} write is offered. The CPU
//       must watch ppu_full and stop issuing non-control writes while it is
//       high. A non-control write issued while full is dropped and latches
//       overflow.
//     * Memory side: mem_we is valid, mem_ready is ready. A write transfers on
//       a clock edge where mem_we && mem_ready. While mem_we is high and
//       mem_ready is low, mem_addr and mem_wdata are held stable.
//
//   Modports:
//     master : the CPU/PPU environment. Drives the inputs and observes status.
//     slave  : the receiver (ppu_stype_rx).
interface ppu_stype_rx_if #(
  parameter int FIFO_DEPTH = 8,
  parameter int IDX_W      = 10,
  parameter int VAL_W      = 16,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
);
  // CPU S-type write channel
  logic             PPU_en;
  logic [IDX_W-1:0] S_type_index;
  logic [VAL_W-1:0] S_type_value;
  // PPU timing / memory port
  logic             vblank;
  logic             mem_ready;
  logic             mem_we;
  logic [IDX_W-1:0] mem_addr;
  logic [VAL_W-1:0] mem_wdata;
  // Status and control
  logic             ppu_full;
  logic             overflow;
  logic [CNT_W-1:0] fifo_count;
  logic [VAL_W-1:0] ctrl_reg;

  modport master (
    output PPU_en, S_type_index, S_type_value, vblank, mem_ready,
    input  mem_we, mem_addr, mem_wdata, ppu_full, overflow, fifo_count, ctrl_reg
  );

  modport slave (
    input  PPU_en, S_type_index, S_type_value, vblank, mem_ready,
    output mem_we, mem_addr, mem_wdata, ppu_full, overflow, fifo_count, ctrl_reg
  );
endinterface

// File: rtl/ppu_stype_rx.sv
// ppu_stype_rx
//   PPU-side receiver for the CPU S-type write channel. CPU writes are queued
//   in a small FIFO and replayed in issue order onto the PPU memory write
//   port, but only while draining is allowed (vertical blank). One reserved
//   index (CTRL_IDX) writes the local control register directly and never
//   enters the FIFO.
//
//   Ports:
//     clk        system clock, all logic on posedge
//     rst        asynchronous, active-low reset (0 = reset)
//     bus        ppu_stype_rx_if.slave. Carries the CPU channel, the memory
//                port, and the status/control outputs.
//     dbg_state  current drain FSM state (0 = IDLE, 1 = WRITE)
//
//   Configuration:
//     STYPE_RX_FORCE_DRAIN_EN
//       When defined, ctrl_reg[15] forces draining outside vblank, for
//       example during a forced-blank load. When undefined, draining follows
//       vblank only and ctrl_reg[15] is plain storage.
//
//   FIFO_DEPTH must be a power of two and at least 2. The read and write
//   pointers wrap by natural binary overflow.
module ppu_stype_rx #(
  parameter int               FIFO_DEPTH = 8,
  parameter int               IDX_W      = 10,
  parameter int               VAL_W      = 16,
  parameter logic [IDX_W-1:0] CTRL_IDX   = 10'h3FF
) (
  input  logic          clk,
  input  logic          rst,
  ppu_stype_rx_if.slave bus,
  output logic [0:0]    dbg_state
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_WRITE = 1'b1;

  // FIFO storage. Address and data are kept in separate arrays so each
  // field goes straight to its output register.
  logic [IDX_W-1:0] addr_mem [FIFO_DEPTH];
  logic [VAL_W-1:0] data_mem [FIFO_DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic [0:0]       state;
  logic             mem_we_q;
  logic [IDX_W-1:0] mem_addr_q;
  logic [VAL_W-1:0] mem_wdata_q;
  logic             overflow_q;
  logic [VAL_W-1:0] ctrl_q;

  logic is_ctrl;
  logic full;
  logic empty;
  logic push;
  logic drop;
  logic pop;
  logic drain_ok;

  // ------------------------------------------------------------------
  // Accept / drain decisions
  // ------------------------------------------------------------------
  always_comb begin
    is_ctrl = (bus.S_type_index == CTRL_IDX);
    full    = (count == CNT_W'(FIFO_DEPTH));
    empty   = (count == '0);

    // Fullness comes from the registered count. A push offered while full is
    // rejected even if the head is popped on the same edge.
    push = bus.PPU_en && !is_ctrl && !full;
    drop = bus.PPU_en && !is_ctrl &&  full;

`ifdef STYPE_RX_FORCE_DRAIN_EN
    drain_ok = bus.vblank | ctrl_q[15];
`else
    drain_ok = bus.vblank;
`endif

    // The head can move to the output registers when they are free. They are
    // free in IDLE, or in WRITE when the presented write retires this edge.
    // Emptiness is judged on the registered count, so an entry pushed this
    // edge is popped at the next edge at the earliest.
    pop = !empty && drain_ok && ((state == ST_IDLE) || bus.mem_ready);
  end

  // ------------------------------------------------------------------
  // FIFO storage (contents need no reset; occupancy is tracked by count)
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= bus.S_type_index;
      data_mem[wr_ptr] <= bus.S_type_value;
    end
  end

  // ------------------------------------------------------------------
  // Pointers and occupancy
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // ------------------------------------------------------------------
  // Control register and sticky overflow
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      // Control writes bypass the FIFO and are accepted even when it is full.
      if (bus.PPU_en && is_ctrl) ctrl_q <= bus.S_type_value;
      // Overflow only ever sets. Reset is the sole way to clear it.
      if (drop) overflow_q <= 1'b1;
    end
  end

  // ------------------------------------------------------------------
  // Drain FSM: IDLE presents nothing, WRITE holds one write on the port.
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pop) begin
            mem_we_q    <= 1'b1;
            mem_addr_q  <= addr_mem[rd_ptr];
            mem_wdata_q <= data_mem[rd_ptr];
            state       <= ST_WRITE;
          end else begin
            mem_we_q <= 1'b0;
          end
        end
        ST_WRITE: begin
          // Without mem_ready everything holds, so address and data stay
          // stable. On retirement, either chain straight into the next
          // entry (back-to-back) or fall back to IDLE. A vblank drop here
          // lets the current write finish but stops further pops.
          if (bus.mem_ready) begin
            if (pop) begin
              mem_addr_q  <= addr_mem[rd_ptr];
              mem_wdata_q <= data_mem[rd_ptr];
            end else begin
              mem_we_q <= 1'b0;
              state    <= ST_IDLE;
            end
          end
        end
        default: begin
          mem_we_q <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

  // ------------------------------------------------------------------
  // Outputs. Everything is registered except ppu_full, which is decoded
  // from the count register.
  // ------------------------------------------------------------------
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.ppu_full   = full;
  assign bus.overflow   = overflow_q;
  assign bus.fifo_count = count;
  assign bus.ctrl_reg   = ctrl_q;
  assign dbg_state      = state;

endmodule

// File: tb/tb_ppu_stype_rx.sv
module tb_ppu_stype_rx;

  localparam int               FIFO_DEPTH = 8;
  localparam int               IDX_W      = 10;
  localparam int               VAL_W      = 16;
  localparam int               CNT_W      = 4;
  localparam logic [IDX_W-1:0] CTRL_IDX   = 10'h3FF;
  localparam int               EW         = IDX_W + VAL_W;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic [0:0] dbg_state;

  always #5 clk = ~clk;

  ppu_stype_rx_if #(.FIFO_DEPTH(FIFO_DEPTH), .IDX_W(IDX_W), .VAL_W(VAL_W), .CNT_W(CNT_W)) bus ();

  ppu_stype_rx #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .IDX_W     (IDX_W),
    .VAL_W     (VAL_W),
    .CTRL_IDX  (CTRL_IDX)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .dbg_state(dbg_state)
  );

  // ---------------- reference model ----------------
  // Transaction-level view: a queue of pending writes, at most one write
  // sitting on the memory port, a control register and an overflow flag.
  logic [EW-1:0]    exp_q[$];
  logic             slot_v;
  logic [EW-1:0]    slot;
  logic [VAL_W-1:0] m_ctrl;
  logic             m_ovf;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic void model_reset();
    exp_q.delete();
    slot_v = 1'b0;
    slot   = '0;
    m_ctrl = '0;
    m_ovf  = 1'b0;
  endfunction

  // Effect of one clock edge given the inputs presented before it.
  function automatic void model_step(input logic en, input logic [IDX_W-1:0] idx,
                                     input logic [VAL_W-1:0] val, input logic vb,
                                     input logic rdy);
    logic may_drain;
    int   size0;
    size0     = exp_q.size();
    may_drain = vb;
`ifdef STYPE_RX_FORCE_DRAIN_EN
    may_drain = vb | m_ctrl[15];
`endif
    // The port takes the next queued write when it is empty or its current
    // write is accepted. Only writes queued before this edge are eligible.
    if (size0 > 0 && may_drain && (!slot_v || rdy)) begin
      slot   = exp_q.pop_front();
      slot_v = 1'b1;
    end else if (slot_v && rdy) begin
      slot_v = 1'b0;
    end
    if (en) begin
      if (idx == CTRL_IDX)          m_ctrl = val;
      else if (size0 == FIFO_DEPTH) m_ovf  = 1'b1;
      else                          exp_q.push_back({idx, val});
    end
  endfunction

  task automatic check_outputs();
    check("mem_we", 32'(bus.mem_we), 32'(slot_v));
    if (slot_v) begin
      check("mem_addr",  32'(bus.mem_addr),  32'(slot[VAL_W +: IDX_W]));
      check("mem_wdata", 32'(bus.mem_wdata), 32'(slot[VAL_W-1:0]));
    end
    check("fifo_count", 32'(bus.fifo_count), 32'(exp_q.size()));
    check("ppu_full",   32'(bus.ppu_full),   32'(exp_q.size() == FIFO_DEPTH));
    check("overflow",   32'(bus.overflow),   32'(m_ovf));
    check("ctrl_reg",   32'(bus.ctrl_reg),   32'(m_ctrl));
  endtask

  // ---------------- driver ----------------
  // Called at a falling edge: drive inputs, advance the model across the
  // next rising edge, then check at the following falling edge.
  task automatic cycle(input logic en, input logic [IDX_W-1:0] idx,
                       input logic [VAL_W-1:0] val, input logic vb, input logic rdy);
    bus.PPU_en       = en;
    bus.S_type_index = idx;
    bus.S_type_value = val;
    bus.vblank       = vb;
    bus.mem_ready    = rdy;
    model_step(en, idx, val, vb, rdy);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input logic vb, input logic rdy);
    cycle(1'b0, '0, '0, vb, rdy);
  endtask

  task automatic check_no_055();
    check("no_dropped_addr", 32'(bus.mem_we && (bus.mem_addr == 10'h055)), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic             r_en;
    logic [IDX_W-1:0] r_idx;
    logic [VAL_W-1:0] r_val;
    logic             r_vb;
    logic             r_rdy;

    rst              = 1'b0;
    bus.PPU_en       = 1'b0;
    bus.S_type_index = '0;
    bus.S_type_value = '0;
    bus.vblank       = 1'b0;
    bus.mem_ready    = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs();
    check("reset_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("reset_state", 32'(dbg_state), 32'd0);
    rst = 1'b1;

    // Ordered drain
    cycle(1'b1, 10'h010, 16'hAAAA, 1'b0, 1'b0);
    cycle(1'b1, 10'h011, 16'hBBBB, 1'b0, 1'b0);
    cycle(1'b1, 10'h3FE, 16'h1234, 1'b0, 1'b0);
    check("order_count3", 32'(bus.fifo_count), 32'd3);
    check("order_no_we",  32'(bus.mem_we), 32'd0);
    idle(1'b1, 1'b1);
    check("order_w1", 32'({bus.mem_we, bus.mem_addr, bus.mem_wdata}), 32'({1'b1, 10'h010, 16'hAAAA}));
    idle(1'b1, 1'b1);
    check("order_w2", 32'({bus.mem_we, bus.mem_addr, bus.mem_wdata}), 32'({1'b1, 10'h011, 16'hBBBB}));
    idle(1'b1, 1'b1);
    check("order_w3", 32'({bus.mem_we, bus.mem_addr, bus.mem_wdata}), 32'({1'b1, 10'h3FE, 16'h1234}));
    idle(1'b1, 1'b1);
    check("order_done_we",  32'(bus.mem_we), 32'd0);
    check("order_done_cnt", 32'(bus.fifo_count), 32'd0);

    // Overflow
    for (int i = 0; i < FIFO_DEPTH; i++)
      cycle(1'b1, IDX_W'(10'h100 + i), VAL_W'($urandom), 1'b0, 1'b0);
    check("ovf_full", 32'(bus.ppu_full), 32'd1);
    check("ovf_clear_before", 32'(bus.overflow), 32'd0);
    cycle(1'b1, 10'h055, 16'hDEAD, 1'b0, 1'b1);
    check("ovf_set",   32'(bus.overflow), 32'd1);
    check("ovf_count", 32'(bus.fifo_count), 32'd8);

    // Control write while full, then vblank low
    cycle(1'b1, CTRL_IDX, 16'h8001, 1'b0, 1'b1);
    check("ctrl_val",   32'(bus.ctrl_reg), 32'h8001);
    check("ctrl_count", 32'(bus.fifo_count), 32'd8);
    check("ctrl_ovf",   32'(bus.overflow), 32'd1);
    for (int i = 0; i < 3; i++) begin
      idle(1'b0, 1'b1);
      check_no_055();
    end
`ifdef STYPE_RX_FORCE_DRAIN_EN
    check("force_drain_count", 32'(bus.fifo_count), 32'd5);
`else
    check("no_drain_count", 32'(bus.fifo_count), 32'd8);
    check("no_drain_we",    32'(bus.mem_we), 32'd0);
`endif
    cycle(1'b1, CTRL_IDX, 16'h0000, 1'b0, 1'b1);
    for (int i = 0; i < 12; i++) begin
      idle(1'b1, 1'b1);
      check_no_055();
    end
    check("ovf_drained", 32'(bus.fifo_count), 32'd0);

    // Back-pressure
    cycle(1'b1, 10'h020, 16'h0F0F, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      idle(1'b1, 1'b0);
      check("bp_hold", 32'({bus.mem_we, bus.mem_addr, bus.mem_wdata}), 32'({1'b1, 10'h020, 16'h0F0F}));
    end
    idle(1'b1, 1'b1);
    check("bp_retired", 32'(bus.mem_we), 32'd0);

    // vblank drop mid-burst
    for (int i = 0; i < 4; i++)
      cycle(1'b1, IDX_W'(10'h200 + i), VAL_W'(16'h5000 + i), 1'b0, 1'b0);
    idle(1'b1, 1'b1);
    idle(1'b1, 1'b1);
    check("vbd_w2", 32'(bus.mem_addr), 32'h201);
    idle(1'b0, 1'b1);
    check("vbd_stop_we",  32'(bus.mem_we), 32'd0);
    check("vbd_stop_cnt", 32'(bus.fifo_count), 32'd2);
    idle(1'b0, 1'b1);
    idle(1'b0, 1'b1);
    check("vbd_hold_cnt", 32'(bus.fifo_count), 32'd2);
    idle(1'b1, 1'b1);
    check("vbd_w3", 32'(bus.mem_addr), 32'h202);
    idle(1'b1, 1'b1);
    check("vbd_w4", 32'(bus.mem_addr), 32'h203);
    idle(1'b1, 1'b1);

    // Randomized traffic
    r_vb = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 19) == 0) r_vb = ~r_vb;
      r_en  = ($urandom_range(0, 9) < 6);
      r_idx = ($urandom_range(0, 7) == 0) ? CTRL_IDX : IDX_W'($urandom_range(0, 10'h3FE));
      r_val = VAL_W'($urandom);
      r_rdy = ($urandom_range(0, 9) < 7);
      cycle(r_en, r_idx, r_val, r_vb, r_rdy);
    end

    // Asynchronous reset in the middle of a drain
    cycle(1'b1, CTRL_IDX, 16'h00F1, 1'b0, 1'b1);
    for (int i = 0; i < 14; i++) idle(1'b1, 1'b1);
    for (int i = 0; i < FIFO_DEPTH + 1; i++)
      cycle(1'b1, IDX_W'(10'h300 + i), VAL_W'($urandom), 1'b0, 1'b0);
    idle(1'b1, 1'b0);
    check("pre_rst_we",  32'(bus.mem_we), 32'd1);
    check("pre_rst_ovf", 32'(bus.overflow), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check("rst_mem_we",   32'(bus.mem_we), 32'd0);
    check("rst_count",    32'(bus.fifo_count), 32'd0);
    check("rst_full",     32'(bus.ppu_full), 32'd0);
    check("rst_overflow", 32'(bus.overflow), 32'd0);
    check("rst_ctrl",     32'(bus.ctrl_reg), 32'd0);
    check("rst_addr",     32'(bus.mem_addr), 32'd0);
    bus.PPU_en = 1'b0;
    @(negedge clk);
    check_outputs();
    rst = 1'b1;

    // Traffic after reset
    cycle(1'b1, 10'h0AB, 16'hCAFE, 1'b1, 1'b1);
    idle(1'b1, 1'b1);
    check("post_rst_w", 32'({bus.mem_we, bus.mem_addr, bus.mem_wdata}), 32'({1'b1, 10'h0AB, 16'hCAFE}));
    idle(1'b1, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
